// File: rtl/instr_mem_arbiter_if.sv
// Bundles the two requester ports and the instruction-memory port of instr_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface instr_mem_arbiter_if #(
   parameter int WORD_WIDTH = 32
);
   logic                  m0_req_i;
   logic                  m1_req_i;
   logic [WORD_WIDTH-1:0] m0_addr_i;
   logic [WORD_WIDTH-1:0] m1_addr_i;
   logic                  m0_gnt_o;
   logic                  m1_gnt_o;
   logic                  m0_rvalid_o;
   logic                  m1_rvalid_o;
   logic [WORD_WIDTH-1:0] m0_rdata_o;
   logic [WORD_WIDTH-1:0] m1_rdata_o;
   logic                  instr_req_o;
   logic [WORD_WIDTH-1:0] instr_addr_o;
   logic                  instr_gnt_i;
   logic [WORD_WIDTH-1:0] instr_rdata_i;
   logic                  instr_rvalid_i;
   logic [2:0]            outstanding_o;
   logic                  err_o;

   modport slave (
      input  m0_req_i, m1_req_i, m0_addr_i, m1_addr_i,
      input  instr_gnt_i, instr_rdata_i, instr_rvalid_i,
      output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
      output instr_req_o, instr_addr_o, outstanding_o, err_o
   );

   modport master (
      output m0_req_i, m1_req_i, m0_addr_i, m1_addr_i,
      output instr_gnt_i, instr_rdata_i, instr_rvalid_i,
      input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
      input  instr_req_o, instr_addr_o, outstanding_o, err_o
   );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Round-robin, grant-locking arbiter sharing one instruction-memory port between fetch (0)
// and loader/debug (1); a 1-bit requester-ID FIFO steers each rvalid back to its issuer.
module instr_mem_arbiter #(
   parameter int WORD_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_mem_arbiter_if.slave  bus
);
   localparam int             PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [2:0]     MAX_CNT  = 3'(MAX_OUTSTANDING);
   localparam logic [PW-1:0]  LAST_PTR = PW'(MAX_OUTSTANDING - 1);

   logic                       lock_q, lock_d;
   logic                       lock_id_q, lock_id_d;
   logic                       last_q, last_d;
   logic                       err_q, err_d;
   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [2:0]                 count_q, count_d;

   logic full_s, empty_s, sel_s, req_sel_s, instr_req_s, push_s, pop_s, head_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   assign full_s  = (count_q == MAX_CNT);
   assign empty_s = (count_q == 3'd0);
   assign head_s  = fifo_q[rd_ptr_q];

   // A locked owner keeps the port until granted; otherwise a tie goes to the port not served last.
   always_comb begin
      sel_s = 1'b0;
      if (lock_q) begin
         sel_s = lock_id_q;
      end else if (bus.m0_req_i && bus.m1_req_i) begin
         sel_s = ~last_q;
      end else if (bus.m1_req_i) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   assign req_sel_s   = sel_s ? bus.m1_req_i : bus.m0_req_i;
   assign instr_req_s = req_sel_s & ~full_s & rst_n;
   assign push_s      = instr_req_s & bus.instr_gnt_i;
   assign pop_s       = bus.instr_rvalid_i & ~empty_s & rst_n;

   assign bus.instr_req_o   = instr_req_s;
   assign bus.instr_addr_o  = instr_req_s ? (sel_s ? bus.m1_addr_i : bus.m0_addr_i)
                                          : {WORD_WIDTH{1'b0}};
   assign bus.m0_gnt_o      = push_s & ~sel_s;
   assign bus.m1_gnt_o      = push_s & sel_s;
   assign bus.m0_rvalid_o   = pop_s & ~head_s;
   assign bus.m1_rvalid_o   = pop_s & head_s;
   assign bus.m0_rdata_o    = rst_n ? bus.instr_rdata_i : {WORD_WIDTH{1'b0}};
   assign bus.m1_rdata_o    = rst_n ? bus.instr_rdata_i : {WORD_WIDTH{1'b0}};
   assign bus.outstanding_o = count_q;
   assign bus.err_o         = err_q;

   // Next-state: lock follows an ungranted request (drops if the owner withdraws), FIFO push/pop.
   always_comb begin
      lock_d    = instr_req_s & ~bus.instr_gnt_i;
      lock_id_d = instr_req_s ? sel_s : lock_id_q;
      last_d    = last_q;
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_d     = err_q;
      if (push_s) begin
         fifo_d[wr_ptr_q] = sel_s;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
         last_d           = sel_s;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (bus.instr_rvalid_i && rst_n) begin
         err_d = 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         last_q    <= 1'b1;
         err_q     <= 1'b0;
         fifo_q    <= {MAX_OUTSTANDING{1'b0}};
         wr_ptr_q  <= {PW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         count_q   <= 3'd0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         last_q    <= last_d;
         err_q     <= err_d;
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end
endmodule
